// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 keyboard transmitter.
//   PS2_FRAME_BITS : bits per PS/2 frame (start, 8 data, parity, stop)
//   PS2_BREAK_CODE : prefix byte sent ahead of a released key
//   ps2_state_e    : transmitter FSM states
//   odd_parity()   : parity bit that makes data+parity hold an odd count of ones
//   make_frame()   : full 11-bit frame, bit 0 is the first bit on the wire
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    SHIFT,
    GAP
  } ps2_state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // {stop, parity, data[7:0], start}; data goes out LSB first.
  function automatic logic [PS2_FRAME_BITS-1:0] make_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: single-clock FIFO with first-word-fall-through read port.
//   clk, rst        : clock, asynchronous active-high reset (pointers only)
//   push, wr_data   : write request and data; ignored while full
//   pop             : read request; ignored while empty
//   rd_data         : head entry, valid whenever empty is low
//   full, empty     : status flags
// Pointers carry one extra wrap bit so full and empty are told apart by the
// MSB alone; DEPTH must be a power of two and at least 2.
module ps2_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO refuses a push even if the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: PS/2 device-side (keyboard) transmitter.
//   clk, rst  : system clock, asynchronous active-high reset
//   in_valid  : in_data holds a byte to queue
//   in_ready  : FIFO can accept a byte (!full)
//   in_data   : scancode byte
//   in_break  : release flag, only meaningful with PS2_KBD_TX_BREAK_EN
//   ps2_clk   : PS/2 clock, idle high, registered
//   ps2_data  : PS/2 data, idle high, registered
//   busy      : frame or gap in progress, or bytes queued
// Each byte becomes one 11-bit frame; a bit period is 2*CLK_DIV clk cycles,
// ps2_clk high for the first half and low for the second, with data stable
// across the falling edge. IDLE_GAP (>=1) idle bit periods follow every frame.
// Build option PS2_KBD_TX_BREAK_EN: FIFO entries carry in_break, and a
// flagged entry is sent as F0, gap, then the byte.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int IDLE_GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_break,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int PERIOD  = 2 * CLK_DIV;
  localparam int GAP_CYC = IDLE_GAP * PERIOD;
  localparam int CNT_MAX = (GAP_CYC > PERIOD) ? GAP_CYC : PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

`ifdef PS2_KBD_TX_BREAK_EN
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
`endif

  ps2_state_e                state;
  logic [CNT_W-1:0]          cnt;
  logic [3:0]                bit_idx;
  logic [PS2_FRAME_BITS-2:0] tail_q;      // frame bits still to send after the start bit
  logic [PS2_FRAME_BITS-1:0] frame_next;
  logic                      frame_load;
  logic [ENTRY_W-1:0]        wr_entry;
  logic [ENTRY_W-1:0]        rd_entry;
  logic [7:0]                head_byte;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic                      period_end;

`ifdef PS2_KBD_TX_BREAK_EN
  logic       pend_q;     // byte frame still owed after the F0 prefix
  logic [7:0] hold_q;
  logic       hold_load;
  assign wr_entry = {in_break, in_data};
`else
  logic unused_break;
  assign unused_break = in_break;
  assign wr_entry     = in_data;
`endif

  assign head_byte  = rd_entry[7:0];
  assign in_ready   = !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign busy       = (state != IDLE) || !fifo_empty;
  assign period_end = (cnt == PER_LAST);

  ps2_tx_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame selection: a new frame starts from IDLE on a pop, or from PREFIX
  // when the byte held back behind an F0 goes out.
  always_comb begin
    frame_load = 1'b0;
    frame_next = make_frame(head_byte);
`ifdef PS2_KBD_TX_BREAK_EN
    hold_load  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          frame_load = 1'b1;
`ifdef PS2_KBD_TX_BREAK_EN
          if (rd_entry[8]) begin
            frame_next = make_frame(PS2_BREAK_CODE);
            hold_load  = 1'b1;
          end
`endif
        end
      end
`ifdef PS2_KBD_TX_BREAK_EN
      PREFIX: begin
        frame_load = 1'b1;
        frame_next = make_frame(hold_q);
      end
`endif
      default: ;
    endcase
  end

  // Shift data: the start bit leaves directly from frame_next, the rest is
  // shifted out of tail_q one bit per period.
  always_ff @(posedge clk) begin
    if (frame_load) begin
      tail_q <= frame_next[PS2_FRAME_BITS-1:1];
    end else if (state == SHIFT && period_end) begin
      tail_q <= {1'b1, tail_q[PS2_FRAME_BITS-2:1]};
    end
`ifdef PS2_KBD_TX_BREAK_EN
    if (hold_load) hold_q <= head_byte;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
`ifdef PS2_KBD_TX_BREAK_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          cnt      <= '0;
          bit_idx  <= '0;
          if (frame_load) begin
            ps2_data <= frame_next[0];
            state    <= SHIFT;
`ifdef PS2_KBD_TX_BREAK_EN
            pend_q   <= hold_load;
`endif
          end
        end
`ifdef PS2_KBD_TX_BREAK_EN
        PREFIX: begin
          ps2_clk  <= 1'b1;
          ps2_data <= frame_next[0];
          cnt      <= '0;
          bit_idx  <= '0;
          pend_q   <= 1'b0;
          state    <= SHIFT;
        end
`endif
        SHIFT: begin
          if (period_end) begin
            cnt     <= '0;
            ps2_clk <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
              ps2_data <= 1'b1;
              state    <= GAP;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              ps2_data <= tail_q[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
            // Falling edge halfway through the period; data is not touched.
            if (cnt == HALF_LAST) ps2_clk <= 1'b0;
          end
        end
        GAP: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (cnt == GAP_LAST) begin
            cnt <= '0;
`ifdef PS2_KBD_TX_BREAK_EN
            state <= pend_q ? PREFIX : IDLE;
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
